alu_writeback_stage: RTL and testbench
======================================

# alu_writeback_stage

Registered stage directly downstream of the 6-bit ALU function units (OR, AND, ADD, …). It captures each unit's result `r` and flags `cf`/`sf`/`zf` through a valid/ready handshake and holds the architectural flags register. It evaluates branch conditions against that register and presents the result plus destination index to the register-file write port. It decouples ALU timing from register-file back-pressure with a 2-entry skid buffer.

## Interface
**Parameters**
- `DATA_W`, default 6: result width.
- `REG_ADDR_W`, default 2: destination register index width.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: ALU result valid.
- `in_ready` out 1: stage can accept.
- `in_r` in `DATA_W`: ALU result.
- `in_cf`, `in_sf`, `in_zf` in 1 each: ALU flags.
- `in_rd` in `REG_ADDR_W`: destination register.
- `in_flags_we` in 1: this op updates the flags register.
- `flush` in 1: discard buffered and incoming entries.
- `out_valid` out 1: write-port data valid.
- `out_ready` in 1: register file accepts.
- `out_r` out `DATA_W`: result to write.
- `out_rd` out `REG_ADDR_W`: destination.
- `flags` out 3: architectural {cf, sf, zf}.
- `cond` in 3: condition code select.
- `cond_true` out 1: `cond` satisfied by `flags`.

## Operation
- Accept occurs when `in_valid & in_ready`. Transfer occurs when `out_valid & out_ready`.
- Buffer entries hold {r, rd}. Output always comes from the main slot. The skid slot fills only when the main slot is occupied, is not draining, and an accept occurs.
- When the main slot drains and the skid slot is valid, the skid entry moves to main. Entries leave strictly in FIFO order.
- `in_ready = !skid_valid`. It is registered, with no combinational path from `out_ready`.
- Flags register:
  - Updated on an accept with `in_flags_we=1`, taking {`in_cf`, `in_sf`, `in_zf`}.
  - An accept with `in_flags_we=0` leaves it unchanged.
  - Flags are updated at accept time, independent of output back-pressure.
- `cond_true` is combinational from `flags` and `cond`:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 C
  - 100 !C
  - 101 S
  - 110 !S
  - 111 never
- `flush`:
  - Both slot valids clear on the next edge.
  - An input presented in the flush cycle is dropped, and its flags update is suppressed.
  - A transfer in the flush cycle still counts as completed.
- Widths are pass-through. The stage does no arithmetic.

## Timing
- Reset values: `out_valid=0`, `out_r=0`, `out_rd=0`, `flags=3'b000`, `in_ready=1`, and both slots empty.
- Latency: accept at edge N gives `out_valid=1` after edge N, when the buffer was empty.
- Throughput: 1 per cycle while `out_ready=1`.
- Full condition: both slots valid gives `in_ready=0`. After one transfer, `in_ready=1` on the following cycle.
- Simultaneous accept and transfer with only the main slot valid: the new entry goes to main and the skid slot stays empty.
- Flags are visible on `flags` and `cond_true` the cycle after the accepting edge.
- Reset asserted mid-transfer: all state clears immediately, asynchronously. Any in-flight entries are lost.

## Configuration
- `ALU_WB_SKID_BUFFER_EN`
  - Defined: 2-entry skid buffer as above, with `in_ready` registered.
  - Undefined: single main slot only, with `in_ready = !out_valid | out_ready`. This is a combinational path from `out_ready`. Same 1-cycle latency and full throughput, but back-pressure propagates combinationally.
- Flags and condition behaviour are identical in both builds.

## Structure
- Shared package `alu_pkg`:
  - `ALU_DATA_W=6`.
  - `flags_t` struct {cf, sf, zf}.
  - `cond_e` enum holding the eight condition encodings.
  - Function `eval_cond(flags_t, cond_e)`.
- Sub-module `wb_skid_buffer`: generic payload skid buffer, parameterised on payload width, carrying {r, rd}. The flags register and condition logic live in the top module.

## Test plan
- Reset then single accept: `in_r=6'h2A`, `in_rd=1`, `in_flags_we=1`, flags {0,1,0}, `out_ready=1`. Expect `out_valid` for one cycle with `out_r=6'h2A`, `out_rd=1`, and `flags=3'b010` from the next cycle.
- Back-pressure: `out_ready=0`, three back-to-back inputs 0x01, 0x02, 0x03. Expect `in_ready` to fall after the second accept and the third to be held. Release `out_ready`: outputs appear in order 0x01, 0x02, 0x03 with no drop or duplicate.
- Flags write-enable: accept zf=1 with we=1, then zf=0 with we=0. Expect `flags` zf stays 1. `cond=001` gives `cond_true=1`; `cond=010` gives 0.
- Condition sweep: force each flags value 000–111 and sweep `cond` 0–7. `cond_true` matches `eval_cond` for all 64 cases.
- Flush: both slots full plus `in_valid` with we=1 and zf=1, with `flush=1`. Next cycle `out_valid=0`, `in_ready=1`, and flags unchanged.
- Async reset mid-stream: assert `rst` between edges while `out_valid=1`. Outputs go to reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: result width, flag layout, condition codes and their evaluation.
package alu_pkg;

    localparam int ALU_DATA_W = 6;

    typedef struct packed {
        logic cf;
        logic sf;
        logic zf;
    } flags_t;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'b000,
        COND_Z      = 3'b001,
        COND_NZ     = 3'b010,
        COND_C      = 3'b011,
        COND_NC     = 3'b100,
        COND_S      = 3'b101,
        COND_NS     = 3'b110,
        COND_NEVER  = 3'b111
    } cond_e;

    function automatic logic eval_cond(input flags_t f, input cond_e c);
        logic res;
        res = 1'b0;
        case (c)
            COND_ALWAYS: res = 1'b1;
            COND_Z:      res = f.zf;
            COND_NZ:     res = !f.zf;
            COND_C:      res = f.cf;
            COND_NC:     res = !f.cf;
            COND_S:      res = f.sf;
            COND_NS:     res = !f.sf;
            COND_NEVER:  res = 1'b0;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Generic payload buffer: 2-entry skid with registered in_ready when ALU_WB_SKID_BUFFER_EN
// is defined, otherwise a single slot whose in_ready follows out_ready combinationally.
module wb_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic         accept;
    logic         transfer;

`ifdef ALU_WB_SKID_BUFFER_EN
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q & !flush;
    assign transfer = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (transfer) begin
            main_valid_d = skid_valid_q;
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                main_data_d = skid_data_q;
            end
        end
        // accept implies skid empty, so a draining main slot is free for the new entry
        if (accept) begin
            if (main_valid_q && !transfer) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !main_valid_q | out_ready;
    assign accept   = in_valid & in_ready & !flush;
    assign transfer = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (transfer) begin
            main_valid_d = 1'b0;
        end
        if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end
        if (flush) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end
`endif

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: buffers {r, rd} toward the register file and holds the flags register.
// Buffer depth selected by ALU_WB_SKID_BUFFER_EN (defined: 2-entry skid, undefined: single slot).
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_r,
    input  logic                  in_cf,
    input  logic                  in_sf,
    input  logic                  in_zf,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_flags_we,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_r,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [2:0]            flags,
    input  logic [2:0]            cond,
    output logic                  cond_true
);

    localparam int PAY_W = DATA_W + REG_ADDR_W;

    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] out_payload;
    logic             accept;
    flags_t           flags_q, flags_d;

    assign in_payload = {in_r, in_rd};

    wb_skid_buffer #(
        .W(PAY_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign out_r  = out_payload[REG_ADDR_W +: DATA_W];
    assign out_rd = out_payload[REG_ADDR_W-1:0];

    // Flags follow the accept, not the drain, so back-pressure never delays them
    assign accept = in_valid & in_ready & !flush;

    always_comb begin
        flags_d = flags_q;
        if (accept && in_flags_we) begin
            flags_d = '{cf: in_cf, sf: in_sf, zf: in_zf};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags     = flags_q;
    assign cond_true = eval_cond(flags_q, cond_e'(cond));

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage; expectations adapt to ALU_WB_SKID_BUFFER_EN.
module tb_alu_writeback_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_r;
    logic       in_cf, in_sf, in_zf;
    logic [1:0] in_rd;
    logic       in_flags_we;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_r;
    logic [1:0] out_rd;
    logic [2:0] flags;
    logic [2:0] cond;
    logic       cond_true;

    int unsigned n_vec;
    int unsigned n_bad;

    alu_writeback_stage #(
        .DATA_W    (6),
        .REG_ADDR_W(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_cf      (in_cf),
        .in_sf      (in_sf),
        .in_zf      (in_zf),
        .in_rd      (in_rd),
        .in_flags_we(in_flags_we),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_rd     (out_rd),
        .flags      (flags),
        .cond       (cond),
        .cond_true  (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] f;     // {cf, sf, zf} to load
        logic [7:0] mask;  // bit c = expected cond_true for cond == c
    } cond_vec_t;

    cond_vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] got [$];
        logic       acc;
        logic       trans;
        int         item;

        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{3'b000, 8'h55};
        vecs[1] = '{3'b001, 8'h53};
        vecs[2] = '{3'b010, 8'h35};
        vecs[3] = '{3'b011, 8'h33};
        vecs[4] = '{3'b100, 8'h4D};
        vecs[5] = '{3'b101, 8'h4B};
        vecs[6] = '{3'b110, 8'h2D};
        vecs[7] = '{3'b111, 8'h2B};

        rst = 1'b1; in_valid = 0; in_r = '0; in_cf = 0; in_sf = 0; in_zf = 0;
        in_rd = '0; in_flags_we = 0; flush = 0; out_ready = 1; cond = '0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_flags", flags, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // single accept
        in_valid = 1; in_r = 6'h2A; in_rd = 2'd1; in_flags_we = 1;
        in_cf = 0; in_sf = 1; in_zf = 0;
        tick();
        in_valid = 0; in_flags_we = 0;
        chk("single_out_valid", out_valid, 1);
        chk("single_out_r", out_r, 6'h2A);
        chk("single_out_rd", out_rd, 1);
        chk("single_flags", flags, 3'b010);
        tick();
        chk("single_drained", out_valid, 0);

        // condition sweep over all flag values, back-to-back accepts
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_flags_we = 1; in_r = 6'(i + 8); in_rd = 2'(i);
            {in_cf, in_sf, in_zf} = vecs[i].f;
            tick();
            in_valid = 0; in_flags_we = 0;
            chk("sweep_flags", flags, vecs[i].f);
            chk("sweep_out_r", out_r, 6'(i + 8));
            chk("sweep_in_ready", in_ready, 1);
            for (int c = 0; c < 8; c++) begin
                cond = 3'(c);
                #1;
                chk("sweep_cond_true", cond_true, vecs[i].mask[c]);
            end
        end
        tick();

        // flags write enable
        in_valid = 1; in_flags_we = 1; {in_cf, in_sf, in_zf} = 3'b001;
        tick();
        in_flags_we = 0; {in_cf, in_sf, in_zf} = 3'b110;
        tick();
        in_valid = 0;
        chk("we0_flags", flags, 3'b001);
        cond = 3'b001; #1;
        chk("we0_cond_z", cond_true, 1);
        cond = 3'b010; #1;
        chk("we0_cond_nz", cond_true, 0);
        tick();

        // back-pressure and in-order drain
        in_valid = 1; in_r = 6'h01; in_rd = 2'd0; item = 1;
        for (int cyc = 0; cyc < 16 && got.size() < 3; cyc++) begin
            out_ready = (cyc >= 4);
            #1;
            acc   = in_valid & in_ready;
            trans = out_valid & out_ready;
            if (trans) got.push_back(out_r);
            tick();
            if (acc) begin
                item++;
                if (item > 3) in_valid = 0;
                else in_r = 6'(item);
            end
`ifdef ALU_WB_SKID_BUFFER_EN
            if (cyc == 0) chk("bp_ready_after_1", in_ready, 1);
            if (cyc == 1) chk("bp_ready_after_2", in_ready, 0);
`else
            if (cyc == 0) chk("bp_ready_after_1", in_ready, 0);
`endif
            if (cyc == 3) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_r", out_r, 6'h01);
                chk("bp_hold_ready", in_ready, 0);
            end
        end
        chk("bp_count", got.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk("bp_order", got[k], 6'(k + 1));
        end
        chk("bp_empty", out_valid, 0);
        out_ready = 1;
        tick();

        // flush with buffer full and an input carrying a flags update
        out_ready = 0; in_valid = 1; in_r = 6'h05; in_flags_we = 0;
        tick();
        in_r = 6'h06;
        tick();
        in_r = 6'h07; in_flags_we = 1; {in_cf, in_sf, in_zf} = 3'b111; flush = 1;
        tick();
        flush = 0; in_valid = 0; in_flags_we = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_flags", flags, 3'b001);

        // flush while ready: input is dropped even though in_ready is high
        out_ready = 1; in_valid = 1; in_flags_we = 1; flush = 1; in_r = 6'h09;
        tick();
        flush = 0; in_valid = 0; in_flags_we = 0;
        chk("flush2_out_valid", out_valid, 0);
        chk("flush2_flags", flags, 3'b001);

        // async reset mid-stream
        out_ready = 0; in_valid = 1; in_r = 6'h3F; in_rd = 2'd3;
        in_flags_we = 1; {in_cf, in_sf, in_zf} = 3'b111;
        tick();
        in_valid = 0; in_flags_we = 0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_flags", flags, 3'b111);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_r", out_r, 0);
        chk("arst_out_rd", out_rd, 0);
        chk("arst_flags", flags, 0);
        chk("arst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
